// File: rtl/counter_load_ctrl.sv
// counter_load_ctrl: control-word decode, count assembly and count readback for one 8254 counter.
// Define COUNTER_READBACK_EN to add the read-back command and the status-byte latch.
module counter_load_ctrl #(
    parameter int unsigned COUNTER_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  a,
    input  logic [7:0]  d,
    input  logic [15:0] cur_count,
    input  logic        out_in,
    output logic [15:0] count0,
    output logic        newCount0,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic [7:0]  dout,
    output logic        null_count
);

    typedef enum logic {
        PTR_LSB = 1'b0,
        PTR_MSB = 1'b1
    } byte_ptr_e;

    localparam logic [1:0] ID_C      = 2'(COUNTER_ID);
    localparam logic [1:0] A_CTRL_C  = 2'b11;
    localparam logic [1:0] RW_NONE_C = 2'b00;
    localparam logic [1:0] RW_LSB_C  = 2'b01;
    localparam logic [1:0] RW_MSB_C  = 2'b10;
    localparam logic [1:0] RW_WORD_C = 2'b11;

    logic [15:0] count0_r;
    logic [15:0] count0_s;
    logic        new_count_r;
    logic        new_count_s;
    logic [2:0]  mode_r;
    logic [2:0]  mode_s;
    logic        bcd_r;
    logic        bcd_s;
    logic [1:0]  rw_r;
    logic [1:0]  rw_s;
    logic [7:0]  dout_r;
    logic [7:0]  dout_s;
    logic        null_count_r;
    logic        null_count_s;
    byte_ptr_e   wptr_r;
    byte_ptr_e   wptr_s;
    byte_ptr_e   rptr_r;
    byte_ptr_e   rptr_s;
    logic        latched_r;
    logic        latched_s;
    logic [15:0] latch_r;
    logic [15:0] latch_s;
    logic [7:0]  lsb_hold_r;
    logic [7:0]  lsb_hold_s;
    logic [15:0] rd_src_s;

    logic        ctrl_hit_s;
    logic        data_wr_s;
    logic        data_rd_s;

`ifdef COUNTER_READBACK_EN
    localparam int RB_BIT_C = COUNTER_ID + 1;
    logic        rb_hit_s;
    logic        status_pend_r;
    logic        status_pend_s;
    logic [7:0]  status_r;
    logic [7:0]  status_s;

    assign rb_hit_s = cs & wr & (a == A_CTRL_C) & (d[7:6] == 2'b11) & d[RB_BIT_C];
`else
    logic        unused_out_in_s;

    assign unused_out_in_s = out_in;
`endif

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
        pick_byte = hi ? word[15:8] : word[7:0];
    endfunction

    assign ctrl_hit_s = cs & wr & (a == A_CTRL_C) & (d[7:6] == ID_C);
    assign data_wr_s  = cs & wr & (a == ID_C);
    assign data_rd_s  = cs & rd & (a == ID_C);
    // A pending count latch takes priority over the live count for reads.
    assign rd_src_s   = latched_r ? latch_r : cur_count;

    // Next-state decode for programming, count assembly, latching and readback.
    always_comb begin
        count0_s     = count0_r;
        new_count_s  = 1'b0;
        mode_s       = mode_r;
        bcd_s        = bcd_r;
        rw_s         = rw_r;
        dout_s       = dout_r;
        null_count_s = null_count_r;
        wptr_s       = wptr_r;
        rptr_s       = rptr_r;
        latched_s    = latched_r;
        latch_s      = latch_r;
        lsb_hold_s   = lsb_hold_r;
`ifdef COUNTER_READBACK_EN
        status_pend_s = status_pend_r;
        status_s      = status_r;
`endif

        if (ctrl_hit_s) begin
            if (d[5:4] == RW_NONE_C) begin
                if (!latched_r) begin
                    latched_s = 1'b1;
                    latch_s   = cur_count;
                end else begin
                    latch_s   = latch_r;
                end
            end else begin
                // Reprogramming abandons any half-written count and any held latch.
                rw_s         = d[5:4];
                mode_s       = d[3:1];
                bcd_s        = d[0];
                wptr_s       = PTR_LSB;
                rptr_s       = PTR_LSB;
                latched_s    = 1'b0;
                null_count_s = 1'b1;
            end
        end else if (data_wr_s) begin
            case (rw_r)
                RW_LSB_C: begin
                    count0_s     = {8'h00, d};
                    new_count_s  = 1'b1;
                    null_count_s = 1'b0;
                end
                RW_MSB_C: begin
                    count0_s     = {d, 8'h00};
                    new_count_s  = 1'b1;
                    null_count_s = 1'b0;
                end
                RW_WORD_C: begin
                    if (wptr_r == PTR_LSB) begin
                        lsb_hold_s = d;
                        wptr_s     = PTR_MSB;
                    end else begin
                        count0_s     = {d, lsb_hold_r};
                        new_count_s  = 1'b1;
                        null_count_s = 1'b0;
                        wptr_s       = PTR_LSB;
                    end
                end
                default: begin
                    count0_s = count0_r;
                end
            endcase
        end else begin
            count0_s = count0_r;
        end

`ifdef COUNTER_READBACK_EN
        if (rb_hit_s) begin
            if (!d[5] && !latched_r) begin
                latched_s = 1'b1;
                latch_s   = cur_count;
            end else begin
                latch_s   = latch_s;
            end
            if (!d[4] && !status_pend_r) begin
                status_pend_s = 1'b1;
                status_s      = {out_in, null_count_r, rw_r, mode_r, bcd_r};
            end else begin
                status_s      = status_r;
            end
        end else begin
            status_s = status_s;
        end
`endif

        if (data_rd_s) begin
`ifdef COUNTER_READBACK_EN
            if (status_pend_r) begin
                dout_s        = status_r;
                status_pend_s = 1'b0;
            end else begin
`else
            begin
`endif
                case (rw_r)
                    RW_LSB_C: begin
                        dout_s    = pick_byte(rd_src_s, 1'b0);
                        latched_s = 1'b0;
                    end
                    RW_MSB_C: begin
                        dout_s    = pick_byte(rd_src_s, 1'b1);
                        latched_s = 1'b0;
                    end
                    RW_WORD_C: begin
                        dout_s = pick_byte(rd_src_s, rptr_r == PTR_MSB);
                        if (rptr_r == PTR_MSB) begin
                            rptr_s    = PTR_LSB;
                            latched_s = 1'b0;
                        end else begin
                            rptr_s    = PTR_MSB;
                        end
                    end
                    default: begin
                        dout_s    = 8'h00;
                        latched_s = 1'b0;
                    end
                endcase
            end
        end else begin
            dout_s = dout_r;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count0_r      <= 16'h0000;
            new_count_r   <= 1'b0;
            mode_r        <= 3'b000;
            bcd_r         <= 1'b0;
            rw_r          <= RW_NONE_C;
            dout_r        <= 8'h00;
            null_count_r  <= 1'b0;
            wptr_r        <= PTR_LSB;
            rptr_r        <= PTR_LSB;
            latched_r     <= 1'b0;
            latch_r       <= 16'h0000;
            lsb_hold_r    <= 8'h00;
`ifdef COUNTER_READBACK_EN
            status_pend_r <= 1'b0;
            status_r      <= 8'h00;
`endif
        end else begin
            count0_r      <= count0_s;
            new_count_r   <= new_count_s;
            mode_r        <= mode_s;
            bcd_r         <= bcd_s;
            rw_r          <= rw_s;
            dout_r        <= dout_s;
            null_count_r  <= null_count_s;
            wptr_r        <= wptr_s;
            rptr_r        <= rptr_s;
            latched_r     <= latched_s;
            latch_r       <= latch_s;
            lsb_hold_r    <= lsb_hold_s;
`ifdef COUNTER_READBACK_EN
            status_pend_r <= status_pend_s;
            status_r      <= status_s;
`endif
        end
    end

    assign count0     = count0_r;
    assign newCount0  = new_count_r;
    assign mode       = mode_r;
    assign bcd        = bcd_r;
    assign dout       = dout_r;
    assign null_count = null_count_r;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// tb_counter_load_ctrl: directed bench for counter_load_ctrl (COUNTER_ID=0) with a transaction-level
// model of the counter interface compared against the DUT every cycle.
module tb_counter_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  a = 2'b00;
    logic [7:0]  d = 8'h00;
    logic [15:0] cur_count = 16'h0000;
    logic        out_in = 1'b0;
    logic [15:0] count0;
    logic        newCount0;
    logic [2:0]  mode;
    logic        bcd;
    logic [7:0]  dout;
    logic        null_count;

    counter_load_ctrl #(.COUNTER_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .a(a), .d(d),
        .cur_count(cur_count), .out_in(out_in), .count0(count0), .newCount0(newCount0),
        .mode(mode), .bcd(bcd), .dout(dout), .null_count(null_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int p0;

    // Model state: programmed format, expected outputs, bytes collected/read so far.
    int          m_rw;
    logic [2:0]  m_mode;
    logic        m_bcd;
    logic [15:0] m_count;
    logic        m_pulse;
    logic        m_null;
    logic [7:0]  m_dout;
    logic [7:0]  m_wq[$];
    int          m_rdone;
    bit          m_latched;
    logic [15:0] m_snap;
    logic [7:0]  m_stq[$];

    function automatic int nbytes(input int rw);
        return (rw == 3) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mode = 3'd0; m_bcd = 1'b0; m_count = 16'h0000; m_pulse = 1'b0;
        m_null = 1'b0; m_dout = 8'h00; m_wq.delete(); m_rdone = 0; m_latched = 0;
        m_snap = 16'h0000; m_stq.delete();
    endtask

    task automatic model_apply();
        logic [15:0] src;
        int idx;
        m_pulse = 1'b0;
        if (cs && wr && a == 2'd3) begin
            if (d[7:6] == 2'd0) begin
                if (d[5:4] == 2'd0) begin
                    if (!m_latched) begin m_latched = 1; m_snap = cur_count; end
                end else begin
                    m_rw = int'(d[5:4]); m_mode = d[3:1]; m_bcd = d[0];
                    m_wq.delete(); m_rdone = 0; m_latched = 0; m_null = 1'b1;
                end
            end
`ifdef COUNTER_READBACK_EN
            else if (d[7:6] == 2'd3 && d[1]) begin
                if (!d[5] && !m_latched) begin m_latched = 1; m_snap = cur_count; end
                if (!d[4] && m_stq.size() == 0)
                    m_stq.push_back({out_in, m_null, 2'(m_rw), m_mode, m_bcd});
            end
`endif
        end
        if (cs && wr && a == 2'd0 && m_rw != 0) begin
            m_wq.push_back(d);
            if (m_wq.size() == nbytes(m_rw)) begin
                if (m_rw == 1)      m_count = {8'h00, m_wq[0]};
                else if (m_rw == 2) m_count = {m_wq[0], 8'h00};
                else                m_count = {m_wq[1], m_wq[0]};
                m_wq.delete(); m_pulse = 1'b1; m_null = 1'b0;
            end
        end
        if (cs && rd && a == 2'd0) begin
            if (m_stq.size() > 0) begin
                m_dout = m_stq.pop_front();
            end else if (m_rw == 0) begin
                m_dout = 8'h00; m_latched = 0;
            end else begin
                src = m_latched ? m_snap : cur_count;
                idx = (m_rw == 1) ? 0 : (m_rw == 2) ? 1 : m_rdone;
                m_dout = 8'(src >> (8 * idx));
                m_rdone++;
                if (m_rdone == nbytes(m_rw)) begin m_rdone = 0; m_latched = 0; end
            end
        end
    endtask

    task automatic compare_all();
        n_tests++;
        if ({count0, newCount0, mode, bcd, dout, null_count} !==
            {m_count, m_pulse, m_mode, m_bcd, m_dout, m_null}) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got count0=%h new=%b mode=%0d bcd=%b dout=%h null=%b, expected count0=%h new=%b mode=%0d bcd=%b dout=%h null=%b",
                     $time, count0, newCount0, mode, bcd, dout, null_count,
                     m_count, m_pulse, m_mode, m_bcd, m_dout, m_null);
        end
        if (newCount0 === 1'b1) pulses++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [1:0] aa, input logic [7:0] dd);
        cs = c; wr = w; rd = r; a = aa; d = dd;
        @(posedge clk);
        if (rst_n) model_apply();
        #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        compare_all();
    endtask

    task automatic ctrl(input logic [7:0] dd); step(1'b1, 1'b1, 1'b0, 2'd3, dd); endtask
    task automatic wrd(input logic [7:0] dd);  step(1'b1, 1'b1, 1'b0, 2'd0, dd); endtask
    task automatic rdd();                      step(1'b1, 1'b0, 1'b1, 2'd0, 8'h00); endtask
    task automatic idle();                     step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00); endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        check("rst_count0", count0, 16'h0000);
        check("rst_dout", {8'h00, dout}, 16'h0000);
        check("rst_null", {15'd0, null_count}, 16'h0000);
        rst_n = 1'b1;
        idle();

        // Unprogrammed: reads give zero, writes ignored
        rdd();
        check("unprog_read", {8'h00, dout}, 16'h0000);
        wrd(8'h55);
        check("unprog_write_pulse", {15'd0, newCount0}, 16'h0000);

        // Two-byte load
        ctrl(8'h30);
        check("null_after_ctrl", {15'd0, null_count}, 16'h0001);
        wrd(8'h05);
        check("word_first_no_pulse", {15'd0, newCount0}, 16'h0000);
        wrd(8'h00);
        check("word_count0", count0, 16'h0005);
        check("word_pulse", {15'd0, newCount0}, 16'h0001);
        check("word_null_clear", {15'd0, null_count}, 16'h0000);
        idle();
        check("pulse_one_cycle", {15'd0, newCount0}, 16'h0000);

        // Single-byte loads
        ctrl(8'h10);
        wrd(8'hA7);
        check("lsb_only", count0, 16'h00A7);
        ctrl(8'h20);
        wrd(8'h12);
        check("msb_only", count0, 16'h1200);

        // Counter latch
        ctrl(8'h30);
        cur_count = 16'h1234;
        ctrl(8'h00);
        cur_count = 16'h0FFF;
        ctrl(8'h00);
        rdd();
        check("latch_lsb", {8'h00, dout}, 16'h0034);
        rdd();
        check("latch_msb", {8'h00, dout}, 16'h0012);
        rdd();
        check("live_after_latch", {8'h00, dout}, 16'h00FF);

        // Control word aborts a half-written count
        p0 = pulses;
        wrd(8'h08);
        ctrl(8'h30);
        wrd(8'h0A);
        wrd(8'h00);
        check("abort_count0", count0, 16'h000A);
        check("abort_single_pulse", 16'(pulses - p0), 16'h0001);
        idle();

        // Strobes that must be ignored
        cur_count = 16'h4321;
        rdd();
        step(1'b0, 1'b1, 1'b1, 2'd0, 8'h55);
        step(1'b1, 1'b1, 1'b0, 2'd1, 8'h66);
        ctrl(8'h70);
        step(1'b1, 1'b0, 1'b1, 2'd2, 8'h00);
        check("ignored_dout_hold", {8'h00, dout}, 16'h0021);
        check("ignored_count0", count0, 16'h000A);
        rdd();
        check("rptr_continues", {8'h00, dout}, 16'h0043);

        // Same-cycle read and write
        ctrl(8'h10);
        cur_count = 16'h5AC3;
        step(1'b1, 1'b1, 1'b1, 2'd0, 8'h3C);
        check("rw_same_count0", count0, 16'h003C);
        check("rw_same_dout", {8'h00, dout}, 16'h00C3);

        // Count of zero and mode/bcd fields
        ctrl(8'h30);
        wrd(8'h00);
        wrd(8'h00);
        check("zero_count_pulse", {15'd0, newCount0}, 16'h0001);
        ctrl(8'h3B);
        check("mode_field", {13'd0, mode}, 16'h0005);
        check("bcd_field", {15'd0, bcd}, 16'h0001);

        // Asynchronous reset in the middle of a two-byte write
        ctrl(8'h30);
        wrd(8'h11);
        async_reset();
        check("midrst_count0", count0, 16'h0000);
        check("midrst_mode", {13'd0, mode}, 16'h0000);
        wrd(8'h22);
        check("midrst_no_pulse", {15'd0, newCount0}, 16'h0000);
        check("midrst_ignored", count0, 16'h0000);

        // Read-back command
        ctrl(8'h30);
        wrd(8'h05);
        wrd(8'h00);
        out_in = 1'b1;
        cur_count = 16'hABCD;
        ctrl(8'hE2);
        rdd();
`ifdef COUNTER_READBACK_EN
        check("rb_status", {8'h00, dout}, 16'h00B0);
        rdd();
        check("rb_lsb", {8'h00, dout}, 16'h00CD);
        rdd();
        check("rb_msb", {8'h00, dout}, 16'h00AB);
`else
        check("rb_ignored_lsb", {8'h00, dout}, 16'h00CD);
        rdd();
        check("rb_ignored_msb", {8'h00, dout}, 16'h00AB);
        check("rb_ignored_null", {15'd0, null_count}, 16'h0000);
`endif
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
